// File: rtl/unrank_pkg.sv
// Shared definitions for the combinadic unranking engine: FSM encoding and
// elaboration-time binomial helpers used to build constant tables.
package unrank_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Multiplicative form keeps intermediates small; each step yields C(n,i+1) exactly.
  function automatic int binom(input int n, input int c);
    int r;
    if (c < 0 || n < c) return 0;
    r = 1;
    for (int i = 0; i < c; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  function automatic int binom_limit(input int rows, input int c);
    return binom(rows, c);
  endfunction

endpackage

// File: rtl/unrank_col_search.sv
// Combinational column search: largest row n with C(n,col) <= rem, plus C(n,col).
module unrank_col_search
  import unrank_pkg::*;
#(
  parameter int NUM_WIDTH   = 10,
  parameter int ROWS_NUM    = 13,
  parameter int ROW_WIDTH   = 4,
  parameter int K_MAX       = 4,
  parameter int K_WIDTH     = 3,
  parameter int VALUE_WIDTH = 10
) (
  input  logic [NUM_WIDTH-1:0]   rem,
  input  logic [K_WIDTH-1:0]     col,
  output logic [ROW_WIDTH-1:0]   row,
  output logic [VALUE_WIDTH-1:0] value
);

  logic [K_MAX-1:0][ROWS_NUM-1:0][VALUE_WIDTH-1:0] tbl;
  logic [ROWS_NUM-1:0][VALUE_WIDTH-1:0]            colv;
  logic [ROWS_NUM:0]                               therm;
  logic [ROWS_NUM-1:0]                             onehot;

  for (genvar c = 0; c < K_MAX; c++) begin : g_col
    for (genvar n = 0; n < ROWS_NUM; n++) begin : g_row
      assign tbl[c][n] = VALUE_WIDTH'(binom(n, c + 1));
    end
  end

  always_comb begin
    colv = '0;
    for (int c = 0; c < K_MAX; c++)
      if (col == K_WIDTH'(c + 1)) colv = tbl[c];
  end

  // C(n,col) is non-decreasing in n, so the compare vector is a thermometer.
  for (genvar n = 0; n < ROWS_NUM; n++) begin : g_cmp
    assign therm[n] = 32'(colv[n]) <= 32'(rem);
  end
  assign therm[ROWS_NUM] = 1'b0;
  assign onehot = therm[ROWS_NUM-1:0] ^ therm[ROWS_NUM:1];

  always_comb begin
    row   = '0;
    value = '0;
    for (int n = 0; n < ROWS_NUM; n++) begin
      if (onehot[n]) begin
        row   = row | ROW_WIDTH'(n);
        value = value | colv[n];
      end
    end
  end

endmodule

// File: rtl/unrank_seq_engine.sv
// Sequential combinadic unranker: emits the k rows of a ranked combination,
// highest first, one per accepted handshake, with start/done control.
module unrank_seq_engine
  import unrank_pkg::*;
#(
  parameter int NUM_WIDTH   = 10,
  parameter int ROWS_NUM    = 13,
  parameter int ROW_WIDTH   = 4,
  parameter int K_MAX       = 4,
  parameter int K_WIDTH     = 3,
  parameter int VALUE_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [NUM_WIDTH-1:0] rank,
  input  logic [K_WIDTH-1:0]   k,
  output logic                 busy,
  output logic                 elem_valid,
  input  logic                 elem_ready,
  output logic [ROW_WIDTH-1:0] elem_row,
  output logic                 elem_last,
  output logic                 done,
  output logic                 err
);

  state_t                   state, state_nxt;
  logic [NUM_WIDTH-1:0]     rem;
  logic [K_WIDTH-1:0]       col;
  logic [ROW_WIDTH-1:0]     s_row;
  logic [VALUE_WIDTH-1:0]   s_val;
  logic [K_MAX:1][VALUE_WIDTH-1:0] lims;
  logic [VALUE_WIDTH-1:0]   lim;
  logic                     bad_req, load, xfer_last;

  unrank_col_search #(
    .NUM_WIDTH(NUM_WIDTH), .ROWS_NUM(ROWS_NUM), .ROW_WIDTH(ROW_WIDTH),
    .K_MAX(K_MAX), .K_WIDTH(K_WIDTH), .VALUE_WIDTH(VALUE_WIDTH)
  ) u_search (
    .rem(rem), .col(col), .row(s_row), .value(s_val)
  );

  for (genvar c = 1; c <= K_MAX; c++) begin : g_lim
    assign lims[c] = VALUE_WIDTH'(binom_limit(ROWS_NUM, c));
  end

  always_comb begin
    lim = '0;
    for (int c = 1; c <= K_MAX; c++)
      if (k == K_WIDTH'(c)) lim = lims[c];
  end

  assign bad_req   = (k == '0) || (k > K_WIDTH'(K_MAX)) || (32'(rank) >= 32'(lim));
  assign load      = (state == RUN) && (!elem_valid || elem_ready) && (col != '0);
  assign xfer_last = (state == RUN) && elem_valid && elem_ready && elem_last;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = bad_req ? DONE : RUN;
      RUN:     if (xfer_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rem        <= '0;
      col        <= '0;
      elem_valid <= 1'b0;
      elem_row   <= '0;
      elem_last  <= 1'b0;
      err        <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        rem <= rank;
        col <= k;
        err <= bad_req;
      end
      // A non-last handshake always coincides with a reload, since col!=0 then.
      if (load) begin
        elem_row   <= s_row;
        elem_last  <= (col == K_WIDTH'(1));
        elem_valid <= 1'b1;
        rem        <= rem - NUM_WIDTH'(s_val);
        col        <= col - K_WIDTH'(1);
      end else if (xfer_last) begin
        elem_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_unrank_seq_engine.sv
// Scoreboard bench for unrank_seq_engine: directed cases, expected elements
// and done/err outcomes queued at issue time and checked by a monitor.
module tb_unrank_seq_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [9:0] rank = '0;
  logic [2:0] k = '0;
  logic       busy, elem_valid, elem_ready, elem_last, done, err;
  logic [3:0] elem_row;

  typedef struct packed {logic [3:0] row; logic last;} elem_t;
  elem_t exp_q[$];
  bit    exp_err_q[$];
  int    total = 0;
  int    bad = 0;

  unrank_seq_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rank(rank), .k(k),
    .busy(busy), .elem_valid(elem_valid), .elem_ready(elem_ready),
    .elem_row(elem_row), .elem_last(elem_last), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int row, input bit last);
    elem_t e;
    e.row = 4'(row);
    e.last = last;
    exp_q.push_back(e);
  endtask

  // Monitor: every handshake and every done pulse must match the scoreboard.
  always @(negedge clk) begin
    if (rst_n && elem_valid && elem_ready) begin
      if (exp_q.size() == 0) check("elem_unexpected", 1, 0);
      else begin
        elem_t e;
        e = exp_q.pop_front();
        check("elem_row", int'(elem_row), int'(e.row));
        check("elem_last", int'(elem_last), int'(e.last));
      end
    end
    if (done) begin
      if (exp_err_q.size() == 0) check("done_unexpected", 1, 0);
      else begin
        bit x;
        x = exp_err_q.pop_front();
        check("done_err", int'(err), int'(x));
      end
    end
  end

  task automatic sync;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int kk, input int rr);
    k = 3'(kk);
    rank = 10'(rr);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) return;
    end
    check("done_timeout", 0, 1);
  endtask

  task automatic err_case(input int kk, input int rr, input string name);
    exp_err_q.push_back(1'b1);
    do_start(kk, rr);
    check({name, "_done"}, int'(done), 1);
    check({name, "_valid"}, int'(elem_valid), 0);
    sync;
    check({name, "_idle"}, int'(busy), 0);
    check({name, "_err_hold"}, int'(err), 1);
  endtask

  initial begin
    elem_ready = 1'b1;
    #12;
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(elem_valid), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_row", int'(elem_row), 0);
    rst_n = 1'b1;
    sync;

    // A: k=3 rank=5 -> 4,2,0
    push(4, 0); push(2, 0); push(0, 1); exp_err_q.push_back(1'b0);
    do_start(3, 5);
    check("a_busy", int'(busy), 1);
    check("a_first_latency", int'(elem_valid), 0);
    sync;
    check("a_first_valid", int'(elem_valid), 1);
    wait_done; sync;

    // B: largest legal rank, then first out-of-range rank
    push(12, 0); push(11, 0); push(10, 1); exp_err_q.push_back(1'b0);
    do_start(3, 285);
    wait_done; sync;
    err_case(3, 286, "b_range");

    // C: illegal k values, then k=1
    err_case(0, 0, "c_k0");
    err_case(5, 0, "c_k5");
    push(7, 1); exp_err_q.push_back(1'b0);
    do_start(1, 7);
    check("c_err_cleared", int'(err), 0);
    wait_done; sync;

    // D: backpressure on the second element
    push(3, 0); push(2, 0); push(1, 0); push(0, 1); exp_err_q.push_back(1'b0);
    do_start(4, 0);
    sync;
    sync;
    elem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sync;
      check("d_hold_valid", int'(elem_valid), 1);
      check("d_hold_row", int'(elem_row), 2);
      check("d_hold_last", int'(elem_last), 0);
      check("d_busy", int'(busy), 1);
    end
    elem_ready = 1'b1;
    wait_done; sync;

    // E: start during RUN ignored; start coincident with done ignored
    push(3, 0); push(0, 1); exp_err_q.push_back(1'b0);
    elem_ready = 1'b0;
    do_start(2, 3);
    sync;
    do_start(4, 0);
    check("e_still_busy", int'(busy), 1);
    elem_ready = 1'b1;
    wait_done;
    k = 3'd1; rank = 10'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("e_start_on_done", int'(busy), 0);
    sync;

    // F: async reset mid-stream, then clean restart
    do_start(4, 714);
    sync;
    check("f_pre_valid", int'(elem_valid), 1);
    rst_n = 1'b0;
    #1;
    check("f_async_valid", int'(elem_valid), 0);
    check("f_async_busy", int'(busy), 0);
    check("f_async_done", int'(done), 0);
    sync; sync;
    rst_n = 1'b1;
    sync;
    push(12, 0); push(11, 0); push(10, 0); push(9, 1); exp_err_q.push_back(1'b0);
    do_start(4, 714);
    wait_done; sync;

    sync; sync;
    check("sb_elems_left", exp_q.size(), 0);
    check("sb_done_left", exp_err_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
